// File: rtl/muldiv_sched_if.sv
// Issue/result bundle between the E stage and the HI/LO multiply/divide sequencer.
interface muldiv_sched_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall_req;
  logic        done;

  // Pipeline side: issues ops and observes HI/LO plus stall status.
  modport master (
    output start, op, rs, rt, req,
    input  hi, lo, busy, stall_req, done
  );

  // Sequencer side.
  modport slave (
    input  start, op, rs, rt, req,
    output hi, lo, busy, stall_req, done
  );
endinterface

// File: rtl/muldiv_sched.sv
// HI/LO owner for the E stage: takes MULT/MULTU/DIV/DIVU/MTHI/MTLO issues,
// holds the result pending for a fixed countdown, then commits it to HI/LO.
// A CP0 request in the issue cycle cancels the issue; it never aborts a
// countdown that is already running, since that instruction has committed.
module muldiv_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_sched_if.slave io
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] MULT_LAT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LAT  = CW'(DIV_CYCLES);

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  // Result waiting for the end of the countdown.
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        wr;
  } pend_t;

  logic [CW-1:0] count;
  pend_t         pend, pend_nxt;
  logic [CW-1:0] lat_nxt;
  logic [31:0]   hi_q, lo_q;
  logic          busy, accept, is_md;

  // Run state is implied by a non-zero countdown.
  assign busy   = (count != '0);
  assign accept = io.start & ~io.req & ~busy;
  assign is_md  = ~io.op[2];

  // Arithmetic datapath, evaluated every cycle, captured only on accept.
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               div_zero, div_ovf;
  logic signed [31:0] dvs_s, quo_s, rem_s;
  logic        [31:0] dvs_u, quo_u, rem_u;

  assign prod_s   = $signed({{32{io.rs[31]}}, io.rs}) * $signed({{32{io.rt[31]}}, io.rt});
  assign prod_u   = {32'd0, io.rs} * {32'd0, io.rt};
  assign div_zero = (io.rt == 32'd0);
  // -2^31 / -1 overflows; dividing by 1 instead yields exactly lo=0x80000000, hi=0.
  assign div_ovf  = (io.rs == 32'h8000_0000) && (io.rt == 32'hFFFF_FFFF);
  // Divisor forced to 1 on the zero case only to keep the operator defined;
  // that result is discarded via pend.wr.
  assign dvs_s    = (div_zero | div_ovf) ? 32'sd1 : $signed(io.rt);
  assign dvs_u    = div_zero ? 32'd1 : io.rt;
  assign quo_s    = $signed(io.rs) / dvs_s;
  assign rem_s    = $signed(io.rs) % dvs_s;
  assign quo_u    = io.rs / dvs_u;
  assign rem_u    = io.rs % dvs_u;

  // Select the pending result and countdown length for the issuing op.
  always_comb begin
    pend_nxt = '0;
    lat_nxt  = '0;
    case (io.op)
      OP_MULT: begin
        pend_nxt = '{hi: prod_s[63:32], lo: prod_s[31:0], wr: 1'b1};
        lat_nxt  = MULT_LAT;
      end
      OP_MULTU: begin
        pend_nxt = '{hi: prod_u[63:32], lo: prod_u[31:0], wr: 1'b1};
        lat_nxt  = MULT_LAT;
      end
      OP_DIV: begin
        pend_nxt = '{hi: rem_s, lo: quo_s, wr: ~div_zero};
        lat_nxt  = DIV_LAT;
      end
      OP_DIVU: begin
        pend_nxt = '{hi: rem_u, lo: quo_u, wr: ~div_zero};
        lat_nxt  = DIV_LAT;
      end
      default: ;
    endcase
  end

  // Sequencer state: accept, count down, commit on the final busy edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
      pend  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else if (accept) begin
      case (io.op)
        OP_MTHI: hi_q <= io.rs;
        OP_MTLO: lo_q <= io.rs;
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
          pend  <= pend_nxt;
          count <= lat_nxt;
        end
        default: ;
      endcase
    end else if (busy) begin
      count <= count - CW'(1);
      if (count == CW'(1) && pend.wr) begin
        hi_q <= pend.hi;
        lo_q <= pend.lo;
      end
    end
  end

  assign io.hi        = hi_q;
  assign io.lo        = lo_q;
  assign io.busy      = busy;
  assign io.done      = (count == CW'(1));
  assign io.stall_req = busy | (io.start & is_md & ~io.req);

endmodule

// File: doc/muldiv_sched.md
# muldiv_sched

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the E stage of the five-stage pipeline. It accepts issue requests for MULT/MULTU/DIV/DIVU/MTHI/MTLO, models the fixed execution latency with a countdown, and drives the busy indication consumed by the stall unit. It honours the CP0 exception request (`req`) so that an instruction flushed in E never modifies HI/LO.

## Interface
- `MULT_CYCLES`, default 5, busy cycles for MULT/MULTU (≥1).
- `DIV_CYCLES`, default 10, busy cycles for DIV/DIVU (≥1).
- `clk` in 1: single system clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-low; sampled on the rising edge of `clk`.
- `start` in 1: E-stage instruction is a HI/LO-writing op this cycle.
- `op` in 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 reserved, treated as no-op.
- `rs` in 32: forwarded rs operand (dividend / multiplicand / MTHI/MTLO source).
- `rt` in 32: forwarded rt operand (divisor / multiplier).
- `req` in 1: CP0 exception/interrupt request; cancels any issue in the same cycle.
- `hi` out 32: architectural HI (for MFHI).
- `lo` out 32: architectural LO (for MFLO).
- `busy` out 1: registered, high while a MULT/DIV countdown is running.
- `stall_req` out 1: `busy | (start & op<=3 & !req)`, combinational; the stall unit stalls any HI/LO-touching instruction in D while this is high.
- `done` out 1: high in the last busy cycle (count==1).

## Operation
- State: `count` (width ≥ clog2(max(MULT_CYCLES,DIV_CYCLES))+1), `pend_hi`, `pend_lo`, `pend_wr` (1 bit), `hi`, `lo`.
- Two states, derived from `count`: IDLE (count==0), RUN (count!=0). `busy = (count!=0)`.
- Accept condition: `start & !req & !busy`. A `start` while `busy` is ignored (stall unit guarantees it never happens; bench checks it is harmless).
- On accept, MULT: {pend_hi,pend_lo} = $signed(rs)*$signed(rt) (64-bit); MULTU unsigned; count←MULT_CYCLES; pend_wr←1.
- On accept, DIV: pend_lo = signed quotient truncated toward zero, pend_hi = remainder with sign of dividend; DIVU unsigned; count←DIV_CYCLES. If rt==0: pend_wr←0 (HI/LO unchanged), latency still DIV_CYCLES.
- Special case DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- On accept, MTHI: hi←rs at that edge; MTLO: lo←rs. No countdown, busy stays low.
- RUN: count decrements each edge; at the edge where count==1, if pend_wr then hi←pend_hi, lo←pend_lo; count←0.
- `req` never aborts an already-running countdown (that instruction has left E and is committed); it only blocks a new accept.
- Reserved op with `start`: no effect.

## Timing
- Reset (reset==0 at an edge): hi=0, lo=0, count=0, pend_*=0; hence busy=0, done=0. Reset overrides a simultaneous start and a mid-countdown operation (result discarded).
- Accept at edge E0 → busy high for exactly N cycles (E0..E(N-1) intervals), done high in the final one, HI/LO show new value and busy low after edge EN.
- Back-to-back: a start in the cycle right after busy falls is accepted normally.
- MFHI/MFLO reading in the cycle of a commit edge sees the old value; the stall unit prevents this case via `stall_req`.
- MTHI/MTLO result visible the cycle after accept; no latency.

## Test plan
- Reset: hold reset=0 two cycles with start=1, op=MULT → hi=lo=0, busy=0 throughout.
- MULT rs=0xFFFFFFFE, rt=3 → busy 5 cycles, done in 5th, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=0xFFFFFFF9 (-7), rt=2 → 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU rs=7, rt=0 → 10 busy cycles, HI/LO keep prior values.
- start=1, op=DIV, req=1 same cycle → busy and stall_req stay 0, HI/LO unchanged; req=1 during a running MULT → MULT still commits.
- MTHI rs=0x12345678 then MTLO rs=0x9ABCDEF0 on consecutive cycles → hi/lo updated one cycle after each, busy never asserted; start(MTLO) while busy → ignored.
- reset=0 asserted in 3rd cycle of DIV → count cleared, hi=lo=0, no late commit.
